simu_ram_frame_packer: RTL

- Downstream neighbour of the simulation RAM read sequencer.
- Consumes the sequencer's `rd_req` strobe and the RAM read data `rd_data`. Aligns them for RAM read latency.
- Emits each contiguous `rd_req` burst as one framed event: header, payload words, two trailer words.
- Output is a valid-only stream with no backpressure, because the read sequencer cannot stall. Feeds the layer-2 output link / simulation dump.

---
 rtl/simu_pkg.sv | 34 +++
 rtl/simu_delay_line.sv | 27 ++
 rtl/simu_ram_frame_packer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/simu_pkg.sv
// Shared types and constants for the simulation RAM frame packer.
// Holds field widths, default frame tags, the FSM encoding and the header/trailer-0 word layouts.
package simu_pkg;

   localparam int EVT_W  = 16;
   localparam int CNT_W  = 10;
   localparam int DATA_W = 32;

   localparam logic [7:0] HDR_MAGIC_DEF = 8'hA5;
   localparam logic [7:0] TRL_MAGIC_DEF = 8'h5A;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_TRL0,
      ST_TRL1,
      ST_DROP
   } state_t;

   typedef struct packed {
      logic [7:0]       magic;
      logic [7:0]       rsvd;
      logic [EVT_W-1:0] evt;
   } hdr_t;

   typedef struct packed {
      logic [7:0]       magic;
      logic [13:0]      rsvd;
      logic [CNT_W-1:0] cnt;
   } trl0_t;

endpackage

// File: rtl/simu_delay_line.sv
// Resettable 1-bit shift register aligning rd_req with RAM read data.
// Latency DEPTH cycles; no backpressure.
module simu_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (reset) begin
         sr <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/simu_ram_frame_packer.sv
// Frames each contiguous rd_req burst as header, payload, count trailer, XOR trailer.
// Header one cycle after aligned valid, payload two; valid-only output, no backpressure.
module simu_ram_frame_packer
   import simu_pkg::*;
#(
   parameter int         RD_LAT    = 1,
   parameter logic [7:0] HDR_MAGIC = HDR_MAGIC_DEF,
   parameter logic [7:0] TRL_MAGIC = TRL_MAGIC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              evt_clr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_sop,
   output logic              out_eop,
   output logic [EVT_W-1:0]  evt_num,
   output logic              busy,
   output logic              err_gap,
   output logic              err_ovf
);

   state_t            state, state_nxt;
   logic              v;
   logic              p_vld;
   logic [DATA_W-1:0] p_dat;
   logic [CNT_W-1:0]  word_count;
   logic [DATA_W-1:0] checksum;
   logic              drop_pend;
   logic              clr_pend;
   logic [EVT_W-1:0]  evt_q, evt_nxt;
   logic [DATA_W-1:0] o_dat_d;
   logic              o_vld_d, o_sop_d, o_eop_d;
   hdr_t              hdr_w;
   trl0_t             trl0_w;

   simu_delay_line #(.DEPTH(RD_LAT)) u_align (
      .clk   (clk),
      .reset (reset),
      .d     (rd_req),
      .q     (v)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // A burst rising during either trailer is remembered so TRL1 can divert to DROP.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (v) state_nxt = ST_DATA;
         ST_DATA: if (!v) state_nxt = ST_TRL0;
         ST_TRL0: state_nxt = ST_TRL1;
         ST_TRL1: state_nxt = (drop_pend || v) ? ST_DROP : ST_IDLE;
         ST_DROP: if (!v) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      hdr_w   = '{magic: HDR_MAGIC, rsvd: 8'h00, evt: evt_q};
      trl0_w  = '{magic: TRL_MAGIC, rsvd: 14'b0, cnt: word_count};
      o_dat_d = '0;
      o_vld_d = 1'b0;
      o_sop_d = 1'b0;
      o_eop_d = 1'b0;
      case (state)
         ST_IDLE: if (v) begin
            o_dat_d = hdr_w;
            o_vld_d = 1'b1;
            o_sop_d = 1'b1;
         end
         ST_DATA: if (p_vld) begin
            o_dat_d = p_dat;
            o_vld_d = 1'b1;
         end
         ST_TRL0: begin
            o_dat_d = trl0_w;
            o_vld_d = 1'b1;
         end
         ST_TRL1: begin
            o_dat_d = checksum;
            o_vld_d = 1'b1;
            o_eop_d = 1'b1;
         end
         default: ;
      endcase
   end

   // A clear seen mid-frame also suppresses that frame's closing increment.
   always_comb begin
      evt_nxt = evt_q;
      if (evt_clr)               evt_nxt = '0;
      else if (state == ST_TRL1) evt_nxt = clr_pend ? '0 : evt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p_vld      <= 1'b0;
         p_dat      <= '0;
         word_count <= '0;
         checksum   <= '0;
      end else begin
         p_vld <= v && (state == ST_IDLE || state == ST_DATA);
         p_dat <= rd_data;
         if (state == ST_IDLE && v) begin
            word_count <= CNT_W'(1);
            checksum   <= rd_data;
         end else if (state == ST_DATA && v) begin
            if (word_count != CNT_MAX) word_count <= word_count + 1'b1;
            checksum <= checksum ^ rd_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         evt_q     <= '0;
         clr_pend  <= 1'b0;
         drop_pend <= 1'b0;
         busy      <= 1'b0;
         err_gap   <= 1'b0;
         err_ovf   <= 1'b0;
      end else begin
         out_data  <= o_dat_d;
         out_valid <= o_vld_d;
         out_sop   <= o_sop_d;
         out_eop   <= o_eop_d;
         evt_q     <= evt_nxt;
         busy      <= (state_nxt != ST_IDLE);
         drop_pend <= (state == ST_TRL0) && v;
         if (state == ST_TRL1)
            clr_pend <= 1'b0;
         else if (evt_clr && (state == ST_DATA || state == ST_TRL0))
            clr_pend <= 1'b1;
         if ((state == ST_TRL0 || state == ST_TRL1) && v) err_gap <= 1'b1;
         if (state == ST_DATA && v && word_count == CNT_MAX) err_ovf <= 1'b1;
      end
   end

   assign evt_num = evt_q;

endmodule
